// File: rtl/result_streamer.sv
// Streams the captured optimal rulers one mark per cycle over a valid/ready port.
// The results vector is snapshotted when the search reports done, so later input changes cannot disturb the stream.
module result_streamer #(
  parameter int NUMPOSITIONS = 5,
  parameter int POSBITS      = 9,
  parameter int NUMRESULTS   = 5
) (
  input  logic                                          FXCLK,
  input  logic                                          RESET_IN,
  input  logic [(NUMPOSITIONS+1)*POSBITS*NUMRESULTS-1:0] results,
  input  logic [5:0]                                    numResultsObserved,
  input  logic                                          done,
  output logic [POSBITS-1:0]                            out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [5:0]                                    out_slot,
  output logic                                          out_last,
  output logic                                          finished
);

  localparam int NWORDS = (NUMPOSITIONS + 1) * NUMRESULTS;
  localparam int MW     = (NUMPOSITIONS > 0) ? $clog2(NUMPOSITIONS + 1) : 1;
  localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [MW-1:0] LAST_MARK = MW'(NUMPOSITIONS);
  localparam logic [5:0]    MAX_CNT   = 6'(NUMRESULTS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]         state_reg;
  logic [POSBITS-1:0] snap_reg [NWORDS];
  logic [5:0]         cnt_reg;
  logic [5:0]         slot_reg;
  logic [MW-1:0]      mark_reg;
  logic [PW-1:0]      ptr_reg;

  logic [POSBITS-1:0] res_words [NWORDS];
  logic [5:0]         cnt_next;
  logic               fire;

  // Word k is slot k/(N+1)+1, mark k%(N+1); slot 1 mark 0 sits in the top slice.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_unpack
    assign res_words[gi] = results[(NWORDS-1-gi)*POSBITS +: POSBITS];
  end

  assign cnt_next  = (numResultsObserved > MAX_CNT) ? MAX_CNT : numResultsObserved;
  assign out_valid = (state_reg == SEND);
  assign finished  = (state_reg == FINISH);
  assign out_last  = out_valid && (slot_reg == cnt_reg) && (mark_reg == LAST_MARK);
  assign out_data  = out_valid ? snap_reg[ptr_reg] : '0;
  assign out_slot  = slot_reg;
  assign fire      = out_valid && out_ready;

  always_ff @(posedge FXCLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      slot_reg  <= '0;
      mark_reg  <= '0;
      ptr_reg   <= '0;
      for (int k = 0; k < NWORDS; k++) snap_reg[k] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (done) begin
            snap_reg  <= res_words;
            cnt_reg   <= cnt_next;
            slot_reg  <= 6'd1;
            mark_reg  <= '0;
            ptr_reg   <= '0;
            state_reg <= (cnt_next == 6'd0) ? FINISH : SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (out_last) begin
              state_reg <= FINISH;
            end else begin
              ptr_reg <= ptr_reg + PW'(1);
              if (mark_reg == LAST_MARK) begin
                mark_reg <= '0;
                slot_reg <= slot_reg + 6'd1;
              end else begin
                mark_reg <= mark_reg + MW'(1);
              end
            end
          end
        end
        FINISH: begin
          if (!done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Randomized scoreboard bench for result_streamer: expected words are queued at stimulus time
// and a negedge monitor pops them on every accepted transfer.
module tb_result_streamer;

  localparam int NP = 5;
  localparam int PB = 9;
  localparam int NR = 5;
  localparam int NW = (NP + 1) * NR;
  localparam int RW = NW * PB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] results = '0;
  logic [5:0]    nobs = '0;
  logic          done = 1'b0;
  logic          out_ready = 1'b0;
  logic [PB-1:0] out_data;
  logic          out_valid;
  logic [5:0]    out_slot;
  logic          out_last;
  logic          finished;

  result_streamer #(.NUMPOSITIONS(NP), .POSBITS(PB), .NUMRESULTS(NR)) dut (
    .FXCLK(clk), .RESET_IN(rst), .results(results), .numResultsObserved(nobs),
    .done(done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_slot(out_slot), .out_last(out_last), .finished(finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PB-1:0] data;
    logic [5:0]    slot;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            ready_mode = 0;
  logic [PB-1:0] model_words [NR][NP+1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = toggle every cycle, 2 = random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops one expected word per accepted transfer and checks stall stability.
  initial begin
    exp_t prev;
    exp_t got;
    exp_t e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else if (!out_valid) begin
        check("idle_data_zero", 32'(out_data), 32'd0);
        prev_stall = 1'b0;
      end else begin
        got = '{data: out_data, slot: out_slot, last: out_last};
        if (prev_stall) check("stall_hold", 32'(got), 32'(prev));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0d required=none slot=%0d", out_data, out_slot);
          end else begin
            e = exp_q.pop_front();
            $display("xfer slot=%0d data=%0d last=%0d", out_slot, out_data, out_last);
            check("word_data", 32'(got.data), 32'(e.data));
            check("word_slot", 32'(got.slot), 32'(e.slot));
            check("word_last", 32'(got.last), 32'(e.last));
          end
        end
        prev_stall = !out_ready;
        prev = got;
      end
    end
  end

  task automatic random_words();
    for (int s = 0; s < NR; s++)
      for (int m = 0; m <= NP; m++)
        model_words[s][m] = PB'($urandom);
  endtask

  task automatic pack_results();
    for (int s = 1; s <= NR; s++)
      for (int m = 0; m <= NP; m++)
        results[((NR - s) * (NP + 1) + (NP - m)) * PB +: PB] = model_words[s-1][m];
  endtask

  function automatic int clamp(input int n);
    return (n > NR) ? NR : n;
  endfunction

  task automatic push_expected(input int n);
    int c;
    c = clamp(n);
    for (int s = 1; s <= c; s++)
      for (int m = 0; m <= NP; m++)
        exp_q.push_back('{data: model_words[s-1][m], slot: 6'(s), last: (s == c) && (m == NP)});
  endtask

  // Waits for finished while scrambling inputs; checks drain, latency and teardown.
  task automatic wait_finish(input int c, input int mode);
    int cycles;
    cycles = 0;
    while (!finished && cycles < 1000) begin
      results = {9{$urandom}};
      nobs = 6'($urandom);
      @(posedge clk);
      #2;
      cycles++;
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL finish_timeout actual=%0d required=%0d", cycles, c * (NP + 1));
    end else begin
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("finish_no_valid", 32'(out_valid), 32'd0);
      if (mode == 0) check("finish_latency", 32'(cycles), 32'(c * (NP + 1)));
    end
    done = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    check("finished_cleared", 32'(finished), 32'd0);
  endtask

  task automatic run_stream(input int n, input int mode, input bit drop_early);
    int c;
    c = clamp(n);
    ready_mode = mode;
    pack_results();
    nobs = 6'(n);
    push_expected(n);
    @(posedge clk);
    #2;
    done = 1'b1;
    @(posedge clk);
    #2;
    check("start_valid", 32'(out_valid), 32'(c > 0));
    check("start_finished", 32'(finished), 32'(c == 0));
    if (drop_early) done = 1'b0;
    wait_finish(c, drop_early ? 1 : mode);
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_slot", 32'(out_slot), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Single ruler 0-1-4-10-12-17.
    random_words();
    model_words[0][0] = 0;  model_words[0][1] = 1;  model_words[0][2] = 4;
    model_words[0][3] = 10; model_words[0][4] = 12; model_words[0][5] = 17;
    run_stream(1, 0, 1'b0);

    // Two rulers under toggling back-pressure.
    model_words[1][0] = 0;  model_words[1][1] = 1;  model_words[1][2] = 4;
    model_words[1][3] = 10; model_words[1][4] = 15; model_words[1][5] = 17;
    run_stream(2, 1, 1'b0);

    // Nothing to send, then clamp of 9 down to NUMRESULTS.
    run_stream(0, 0, 1'b0);
    random_words();
    run_stream(9, 2, 1'b0);

    // Reset after the third transfer, restart with done still high.
    random_words();
    ready_mode = 0;
    pack_results();
    nobs = 6'd2;
    push_expected(2);
    @(posedge clk);
    #2;
    done = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_slot", 32'(out_slot), 32'd0);
    check("midrst_finished", 32'(finished), 32'd0);
    exp_q.delete();
    pack_results();
    nobs = 6'd2;
    push_expected(2);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("restart_valid", 32'(out_valid), 32'd1);
    wait_finish(2, 0);

    // Randomized re-arm sequence.
    for (int i = 0; i < 20; i++) begin
      random_words();
      run_stream(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter NUMPOSITIONS, default 5: index of the last mark; each ruler has NUMPOSITIONS+1 marks.
REQ-002 Parameter POSBITS, default 9: width of one mark value.
REQ-003 Parameter NUMRESULTS, default 5: number of ruler slots in the results vector.
REQ-004 FXCLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESET_IN  input  1  reset, asynchronous and active-high.
REQ-006 results  input  (NUMPOSITIONS+1)*POSBITS*NUMRESULTS  stored rulers from the search assembly; slot 1 occupies the most significant slice; within a slot, mark 0 is most significant.
REQ-007 numResultsObserved  input  6  count of optimal rulers found by the search.
REQ-008 done  input  1  level high once the search has finished; results are stable while high.
REQ-009 out_data  output  POSBITS  current mark value.
REQ-010 out_valid  output  1  out_data, out_slot and out_last are valid.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 out_slot  output  6  1-based ruler number of the current word.
REQ-013 out_last  output  1  high on the final mark of the final ruler.
REQ-014 finished  output  1  high once all words are transferred, or when there is nothing to send.

Function
REQ-015 A transfer occurs on a rising edge where out_valid and out_ready are both high.
REQ-016 The FSM has three states: IDLE, SEND, FINISH.
REQ-017 IDLE: on an edge with done=1, capture results into an internal snapshot and latch cnt = min(numResultsObserved, NUMRESULTS).
REQ-018 IDLE exit with cnt>0: go to SEND with slot=1 and mark=0; out_valid rises in the cycle after done is first sampled high.
REQ-019 IDLE exit with cnt=0: go directly to FINISH; out_valid never asserts.
REQ-020 SEND: out_data = snapshot slot out_slot, mark index mark; out_valid=1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_slot and out_last hold stable.
REQ-022 On each transfer the mark index increments; after mark NUMPOSITIONS it wraps to 0 and out_slot increments.
REQ-023 Throughput: one word per cycle when out_ready stays high.
REQ-024 out_last = (out_slot==cnt) and (mark==NUMPOSITIONS).
REQ-025 A transfer with out_last=1 moves the FSM to FINISH; out_valid is 0 in the following cycle.
REQ-026 FINISH: finished=1, out_valid=0; the FSM stays in FINISH while done=1.
REQ-027 FINISH with done=0 returns to IDLE and clears finished the next cycle.
REQ-028 Input changes on results or numResultsObserved after capture have no effect on the current stream.
REQ-029 done falling during SEND does not abort the stream; the FSM completes it and then returns via FINISH.
REQ-030 numResultsObserved values above NUMRESULTS are clamped to NUMRESULTS.
REQ-031 out_data is 0 whenever out_valid=0.

Reset
REQ-032 While RESET_IN=1, the outputs are forced to: state IDLE; out_valid, out_last and finished 0; out_data 0; out_slot 0; snapshot and counters 0.
REQ-033 Reset asserted mid-stream aborts the stream immediately, without waiting for a clock edge.
REQ-034 After reset is released, the block waits in IDLE for done; if done is already high at the first edge, the stream restarts from slot 1.

Verification
REQ-035 Single ruler: slot 1 = 0-1-4-10-12-17, numResultsObserved=1, done=1, out_ready=1 -> words 0,1,4,10,12,17 on six consecutive cycles; out_slot=1; out_last only on 17; finished=1 on the next cycle.
REQ-036 Back-pressure: slots 1-2 = 0-1-4-10-12-17 and 0-1-4-10-15-17, numResultsObserved=2, out_ready toggling 1,0,1,0 -> 12 transfers in order; data held stable during every stall; out_slot changes 1->2 after the sixth transfer.
REQ-037 Zero results: numResultsObserved=0, done=1 -> out_valid stays 0; finished=1 one cycle after done is sampled.
REQ-038 Clamp: numResultsObserved=9 with NUMRESULTS=5 -> 30 words; out_last on slot 5, mark 5.
REQ-039 Reset mid-stream: assert RESET_IN after the third transfer -> out_valid=0 immediately; after release with done still 1 -> stream restarts at slot 1, mark 0 (word 0).
REQ-040 Re-arm: done 1->0 in FINISH -> IDLE; a new done pulse with different results -> new snapshot is streamed.
